kf8255_bus_master: RTL and testbench

Synchronous bus master that sequences all CPU-side accesses to a KF8255 PPI instance. It shares the PPI between two requesters (A, B) using round-robin arbitration and generates `chip_select_n` / `read_enable_n` / `write_enable_n` / `address` with programmable setup, strobe and hold phases. Optionally, it writes a control word after reset so the ports come up in a known mode. It sits between on-chip logic and the KF8255 data bus wrapper.

---
 rtl/kf8255_bus_master_if.sv | 41 ++++
 rtl/kf8255_bus_master.sv | 221 ++++++++++++++++++++++
 tb/tb_kf8255_bus_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kf8255_bus_master_if.sv
// Bundle between the KF8255 bus master and its two requesters plus the PPI.
// master: drives acks, rdata, PPI strobes/address/data, init_done; slave: the rest.
interface kf8255_bus_master_if;
  logic       a_req;
  logic       b_req;
  logic       a_write;
  logic       b_write;
  logic [1:0] a_address;
  logic [1:0] b_address;
  logic [7:0] a_wdata;
  logic [7:0] b_wdata;
  logic       a_ack;
  logic       b_ack;
  logic [7:0] a_rdata;
  logic [7:0] b_rdata;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic [1:0] address;
  logic [7:0] data_bus_out;
  logic [7:0] data_bus_in;
  logic       init_done;

  modport master (
    input  a_req, b_req, a_write, b_write,
    input  a_address, b_address, a_wdata, b_wdata,
    input  data_bus_in,
    output a_ack, b_ack, a_rdata, b_rdata,
    output chip_select_n, read_enable_n, write_enable_n,
    output address, data_bus_out, init_done
  );

  modport slave (
    output a_req, b_req, a_write, b_write,
    output a_address, b_address, a_wdata, b_wdata,
    output data_bus_in,
    input  a_ack, b_ack, a_rdata, b_rdata,
    input  chip_select_n, read_enable_n, write_enable_n,
    input  address, data_bus_out, init_done
  );
endinterface

// File: rtl/kf8255_bus_master.sv
// Round-robin two-requester bus master for a KF8255 PPI with timed phases.
// Ports: clock, reset_n (async low), bus (kf8255_bus_master_if.master).
// KF8255_BUS_MASTER_INIT_EN: write INIT_CONTROL_WORD to address 3 after reset.
module kf8255_bus_master #(
  parameter logic [7:0] INIT_CONTROL_WORD = 8'h9B,
  parameter int         SETUP_CYCLES      = 1,
  parameter int         STROBE_CYCLES     = 2,
  parameter int         HOLD_CYCLES       = 1
) (
  input logic                        clock,
  input logic                        reset_n,
  kf8255_bus_master_if.master        bus
);

  typedef enum logic [2:0] {
    INIT_SETUP,
    INIT_STROBE,
    INIT_HOLD,
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    ACK
  } state_t;

  localparam logic [3:0] S_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] W_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       ptr;
  logic       ptr_nx;
  logic       sel;
  logic       sel_nx;
  logic       is_init;
  logic       is_init_nx;
  logic       cmd_wr;
  logic       cmd_wr_nx;
  logic [1:0] cmd_addr;
  logic [1:0] cmd_addr_nx;
  logic [7:0] cmd_data;
  logic [7:0] cmd_data_nx;
  logic       init_done_q;
  logic       cap_a;
  logic       cap_b;
  logic       bus_ph;
  logic       strb;
  logic       cs_nx;
  logic       rd_nx;
  logic       wr_nx;
  logic [7:0] dout_nx;
  logic       a_ack_nx;
  logic       b_ack_nx;

  // ptr = 1 favours B on a tie; sel = 1 means B owns the bus.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ptr_nx      = ptr;
    sel_nx      = sel;
    is_init_nx  = is_init;
    cmd_wr_nx   = cmd_wr;
    cmd_addr_nx = cmd_addr;
    cmd_data_nx = cmd_data;
    cap_a       = 1'b0;
    cap_b       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!init_done_q) begin
          state_nx    = INIT_SETUP;
          cnt_nx      = S_LD;
          is_init_nx  = 1'b1;
          cmd_wr_nx   = 1'b1;
          cmd_addr_nx = 2'b11;
          cmd_data_nx = INIT_CONTROL_WORD;
        end else if (bus.a_req || bus.b_req) begin
          sel_nx      = bus.b_req && (!bus.a_req || ptr);
          ptr_nx      = !sel_nx;
          state_nx    = SETUP;
          cnt_nx      = S_LD;
          is_init_nx  = 1'b0;
          cmd_wr_nx   = sel_nx ? bus.b_write   : bus.a_write;
          cmd_addr_nx = sel_nx ? bus.b_address : bus.a_address;
          cmd_data_nx = sel_nx ? bus.b_wdata   : bus.a_wdata;
        end
      end
      INIT_SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = INIT_STROBE;
          cnt_nx   = W_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      INIT_STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = INIT_HOLD;
          cnt_nx   = H_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      INIT_HOLD: begin
        if (cnt == 4'd0) begin
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nx = STROBE;
          cnt_nx   = W_LD;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nx = HOLD;
          cnt_nx   = H_LD;
          cap_a    = !cmd_wr && !sel;
          cap_b    = !cmd_wr && sel;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_nx = ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave registers.
  always_comb begin
    bus_ph = (state_nx == INIT_SETUP) || (state_nx == INIT_STROBE) ||
             (state_nx == INIT_HOLD)  || (state_nx == SETUP) ||
             (state_nx == STROBE)     || (state_nx == HOLD);
    strb     = (state_nx == INIT_STROBE) || (state_nx == STROBE);
    cs_nx    = !bus_ph;
    wr_nx    = !(strb && cmd_wr_nx);
    rd_nx    = !(strb && !cmd_wr_nx);
    dout_nx  = (bus_ph && cmd_wr_nx) ? cmd_data_nx : 8'h00;
    a_ack_nx = (state_nx == ACK) && (state != ACK) &&
               !is_init_nx && !sel_nx;
    b_ack_nx = (state_nx == ACK) && (state != ACK) &&
               !is_init_nx && sel_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      ptr                <= 1'b0;
      sel                <= 1'b0;
      is_init            <= 1'b0;
      cmd_wr             <= 1'b0;
      cmd_addr           <= 2'b00;
      cmd_data           <= 8'h00;
      bus.chip_select_n  <= 1'b1;
      bus.read_enable_n  <= 1'b1;
      bus.write_enable_n <= 1'b1;
      bus.data_bus_out   <= 8'h00;
      bus.a_ack          <= 1'b0;
      bus.b_ack          <= 1'b0;
      bus.a_rdata        <= 8'h00;
      bus.b_rdata        <= 8'h00;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      ptr                <= ptr_nx;
      sel                <= sel_nx;
      is_init            <= is_init_nx;
      cmd_wr             <= cmd_wr_nx;
      cmd_addr           <= cmd_addr_nx;
      cmd_data           <= cmd_data_nx;
      bus.chip_select_n  <= cs_nx;
      bus.read_enable_n  <= rd_nx;
      bus.write_enable_n <= wr_nx;
      bus.data_bus_out   <= dout_nx;
      bus.a_ack          <= a_ack_nx;
      bus.b_ack          <= b_ack_nx;
      if (cap_a) begin
        bus.a_rdata <= bus.data_bus_in;
      end
      if (cap_b) begin
        bus.b_rdata <= bus.data_bus_in;
      end
    end
  end

  assign bus.address = cmd_addr;

`ifdef KF8255_BUS_MASTER_INIT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_done_q <= 1'b0;
    end else if ((state == ACK) && is_init) begin
      init_done_q <= 1'b1;
    end
  end
`else
  assign init_done_q = 1'b1;
`endif

  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_kf8255_bus_master.sv
// Directed bench for kf8255_bus_master: default and slow-phase instances.
// Requester inputs are shared by both instances; each is observed separately.
module tb_kf8255_bus_master;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_req = 1'b0;
  logic       b_req = 1'b0;
  logic       a_write = 1'b0;
  logic       b_write = 1'b0;
  logic [1:0] a_address = 2'b00;
  logic [1:0] b_address = 2'b00;
  logic [7:0] a_wdata = 8'h00;
  logic [7:0] b_wdata = 8'h00;
  logic [7:0] data_in = 8'h00;

  always #5 clock = ~clock;

  kf8255_bus_master_if bm ();
  kf8255_bus_master_if bp ();

  assign bm.a_req       = a_req;
  assign bm.b_req       = b_req;
  assign bm.a_write     = a_write;
  assign bm.b_write     = b_write;
  assign bm.a_address   = a_address;
  assign bm.b_address   = b_address;
  assign bm.a_wdata     = a_wdata;
  assign bm.b_wdata     = b_wdata;
  assign bm.data_bus_in = data_in;
  assign bp.a_req       = a_req;
  assign bp.b_req       = b_req;
  assign bp.a_write     = a_write;
  assign bp.b_write     = b_write;
  assign bp.a_address   = a_address;
  assign bp.b_address   = b_address;
  assign bp.a_wdata     = a_wdata;
  assign bp.b_wdata     = b_wdata;
  assign bp.data_bus_in = data_in;

  kf8255_bus_master u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bm.master)
  );

  kf8255_bus_master #(
    .SETUP_CYCLES  (3),
    .STROBE_CYCLES (4),
    .HOLD_CYCLES   (2)
  ) u_slow (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bp.master)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       s_cs, s_rd, s_wr, s_aack, s_back, s_done;
  logic [1:0] s_addr;
  logic [7:0] s_dout;

  task automatic sample(input bit u);
    if (!u) begin
      s_cs = bm.chip_select_n; s_rd = bm.read_enable_n;
      s_wr = bm.write_enable_n; s_aack = bm.a_ack;
      s_back = bm.b_ack; s_done = bm.init_done;
      s_addr = bm.address; s_dout = bm.data_bus_out;
    end else begin
      s_cs = bp.chip_select_n; s_rd = bp.read_enable_n;
      s_wr = bp.write_enable_n; s_aack = bp.a_ack;
      s_back = bp.b_ack; s_done = bp.init_done;
      s_addr = bp.address; s_dout = bp.data_bus_out;
    end
  endtask

  // Called at the negedge of reset release; observes the default unit.
  task automatic check_init(input string tag);
`ifdef KF8255_BUS_MASTER_INIT_EN
    int cs_lo = 0, wr_lo = 0, wr_first = -1, rd_lo = 0, bad = 0, acks = 0;
    logic d5 = 1'b1, d6 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      sample(0);
      if (!s_cs) begin
        cs_lo++;
        if (s_addr != 2'b11 || s_dout != 8'h9B) bad++;
      end
      if (!s_wr) begin
        wr_lo++;
        if (wr_first < 0) wr_first = k;
        if (s_cs) bad++;
      end
      if (!s_rd) rd_lo++;
      if (s_aack || s_back) acks++;
      if (k == 5) d5 = s_done;
      if (k == 6) d6 = s_done;
    end
    check({tag, " cs low cycles"}, cs_lo, 4);
    check({tag, " wr low cycles"}, wr_lo, 2);
    check({tag, " wr first cycle"}, wr_first, 2);
    check({tag, " rd low cycles"}, rd_lo, 0);
    check({tag, " addr/data"}, bad, 0);
    check({tag, " acks"}, acks, 0);
    check({tag, " done c5"}, d5, 0);
    check({tag, " done c6"}, d6, 1);
`else
    @(negedge clock);
    sample(0);
    check({tag, " done"}, s_done, 1);
    check({tag, " cs idle"}, s_cs, 1);
`endif
  endtask

  task automatic run_txn(input bit u, input bit b, input bit wr,
                         input logic [1:0] ad, input logic [7:0] wd,
                         input logic [7:0] din,
                         output int ack_k, output int cs_lo,
                         output int st_lo, output int st_first,
                         output int bad);
    ack_k = -1; cs_lo = 0; st_lo = 0; st_first = -1; bad = 0;
    data_in = din;
    if (b) begin
      b_req = 1'b1; b_write = wr; b_address = ad; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_write = wr; a_address = ad; a_wdata = wd;
    end
    for (int k = 1; k <= 30 && ack_k < 0; k++) begin
      @(negedge clock);
      sample(u);
      if (!s_cs) begin
        cs_lo++;
        if (s_addr != ad || s_dout != (wr ? wd : 8'h00)) bad++;
      end
      if (!s_wr || !s_rd) begin
        st_lo++;
        if (st_first < 0) st_first = k;
        if (s_cs || (wr ? !s_rd : !s_wr)) bad++;
      end
      if (s_aack || s_back) begin
        ack_k = k;
        if (s_aack == b || s_back != b) bad++;
        a_req = 1'b0;
        b_req = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clock);
  endtask

  int ak, cl, sl, sf, bd;
  int ack_who[4];
  int ack_cyc[4];
  int n_ack;

  initial begin
    // Reset state.
    @(negedge clock);
    sample(0);
    check("rst cs_n", s_cs, 1);
    check("rst rd_n", s_rd, 1);
    check("rst wr_n", s_wr, 1);
    check("rst addr", s_addr, 0);
    check("rst dout", s_dout, 0);
    check("rst acks", {s_aack, s_back}, 0);
    check("rst a_rdata", bm.a_rdata, 0);
    check("rst b_rdata", bm.b_rdata, 0);
`ifdef KF8255_BUS_MASTER_INIT_EN
    check("rst init_done", s_done, 0);
`else
    check("rst init_done", s_done, 1);
`endif
    reset_n = 1'b1;
    check_init("init");

    // A writes 55 to address 0.
    run_txn(0, 0, 1, 2'd0, 8'h55, 8'h00, ak, cl, sl, sf, bd);
    check("wrA ack cycle", ak, 5);
    check("wrA cs low", cl, 4);
    check("wrA wr low", sl, 2);
    check("wrA wr first", sf, 2);
    check("wrA bus", bd, 0);

    // A reads address 2, then B reads address 1.
    run_txn(0, 0, 0, 2'd2, 8'hFF, 8'h3C, ak, cl, sl, sf, bd);
    check("rdA ack cycle", ak, 5);
    check("rdA bus", bd, 0);
    check("rdA a_rdata", bm.a_rdata, 8'h3C);
    run_txn(0, 1, 0, 2'd1, 8'hFF, 8'hA7, ak, cl, sl, sf, bd);
    check("rdB ack cycle", ak, 5);
    check("rdB rd low", sl, 2);
    check("rdB rd first", sf, 2);
    check("rdB bus", bd, 0);
    check("rdB b_rdata", bm.b_rdata, 8'hA7);
    check("rdB a_rdata kept", bm.a_rdata, 8'h3C);

    // Both request continuously; last grant went to B so A leads.
    a_write = 1'b1; a_address = 2'd0; a_wdata = 8'h11;
    b_write = 1'b1; b_address = 2'd1; b_wdata = 8'h22;
    a_req = 1'b1; b_req = 1'b1;
    n_ack = 0;
    for (int k = 1; k <= 40 && n_ack < 4; k++) begin
      @(negedge clock);
      sample(0);
      if (s_aack || s_back) begin
        ack_who[n_ack] = s_back ? 1 : 0;
        ack_cyc[n_ack] = k;
        n_ack++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clock);
    check("rr ack count", n_ack, 4);
    check("rr first cycle", ack_cyc[0], 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr who %0d", i), ack_who[i], i % 2);
      if (i > 0) check($sformatf("rr gap %0d", i),
                       ack_cyc[i] - ack_cyc[i-1], 6);
    end

    // Async reset in the middle of a write strobe.
    a_req = 1'b1; a_write = 1'b1; a_address = 2'd2; a_wdata = 8'hAA;
    @(negedge clock);
    @(negedge clock);
    sample(0);
    check("arst wr low before", s_wr, 0);
    #2 reset_n = 1'b0;
    #1 sample(0);
    check("arst wr_n async", s_wr, 1);
    check("arst cs_n async", s_cs, 1);
    a_req = 1'b0;
    bd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      sample(0);
      if (s_aack || s_back || !s_cs) bd++;
    end
    check("arst quiet", bd, 0);
`ifdef KF8255_BUS_MASTER_INIT_EN
    check("arst init_done", s_done, 0);
`endif
    reset_n = 1'b1;
    check_init("reinit");

    // Slow-phase instance read.
    for (int i = 0; i < 20 && !bp.init_done; i++) @(negedge clock);
    check("slow init_done", bp.init_done, 1);
    run_txn(1, 0, 0, 2'd2, 8'h00, 8'hC3, ak, cl, sl, sf, bd);
    check("slow ack cycle", ak, 10);
    check("slow cs low", cl, 9);
    check("slow rd low", sl, 4);
    check("slow rd first", sf, 4);
    check("slow bus", bd, 0);
    check("slow a_rdata", bp.a_rdata, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
